argmax_sequencer: RTL and testbench

ARGMAX_SEQUENCER -- requirements
Module: argmax_sequencer

---
 rtl/argmax_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_argmax_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_sequencer.sv
// Argmax over CLASS_NUM signed class sums, one compare per cycle; ARGMAX_MARGIN_EN adds a best-minus-runner-up output.
// Latency: pred_valid rises on the CLASS_NUM-th edge, counting the edge that samples the adder_done rise.
// Backpressure: the result is held while pred_ready is low; starts that arrive while busy are dropped and counted.
module argmax_sequencer #(
    parameter int CLASS_NUM     = 10,
    parameter int WEIGHT_LENGTH = 16,
    localparam int IDX_W        = ($clog2(CLASS_NUM) > 1) ? $clog2(CLASS_NUM) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            adder_done,
    input  logic signed [WEIGHT_LENGTH-1:0] class_sums [CLASS_NUM],
    input  logic                            pred_ready,
    output logic                            pred_valid,
    output logic [IDX_W-1:0]                pred_class,
    output logic signed [WEIGHT_LENGTH-1:0] pred_sum,
    output logic                            busy,
    output logic [7:0]                      drop_cnt
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic signed [WEIGHT_LENGTH:0]   margin
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASS_NUM - 1);
    localparam bit SINGLE = (CLASS_NUM == 1);

    state_t state, state_n;

    logic                            done_d;
    logic                            start;
    logic                            load;
    logic                            finish;
    logic                            drop;
    logic signed [WEIGHT_LENGTH-1:0] snap [CLASS_NUM];
    logic signed [WEIGHT_LENGTH-1:0] best, best_n, cur;
    logic [IDX_W-1:0]                best_idx, best_idx_n;
    logic [IDX_W-1:0]                idx;

    assign start      = adder_done && !done_d;
    assign pred_valid = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_d <= 1'b1;
        end else begin
            state  <= state_n;
            done_d <= adder_done;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        finish  = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    finish  = SINGLE;
                    state_n = SINGLE ? DONE : SCAN;
                end
            end
            SCAN: begin
                drop = start;
                if (idx == LAST_IDX) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (pred_ready) begin
                    if (start) begin
                        load    = 1'b1;
                        finish  = SINGLE;
                        state_n = SINGLE ? DONE : SCAN;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    drop = start;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        cur = snap[idx];
        if (load) begin
            best_n     = class_sums[0];
            best_idx_n = '0;
        end else if (cur > best) begin
            best_n     = cur;
            best_idx_n = idx;
        end else begin
            best_n     = best;
            best_idx_n = best_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLASS_NUM; i++) snap[i] <= '0;
            best       <= '0;
            best_idx   <= '0;
            idx        <= '0;
            pred_class <= '0;
            pred_sum   <= '0;
        end else begin
            if (load) begin
                for (int i = 0; i < CLASS_NUM; i++) snap[i] <= class_sums[i];
            end
            if (load || state == SCAN) begin
                best     <= best_n;
                best_idx <= best_idx_n;
                idx      <= load ? IDX_W'(1) : idx + IDX_W'(1);
            end
            if (finish) begin
                pred_class <= best_idx_n;
                pred_sum   <= best_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef ARGMAX_MARGIN_EN
    logic signed [WEIGHT_LENGTH-1:0] second, second_n;
    logic                            second_vld, second_vld_n;
    logic signed [WEIGHT_LENGTH:0]   best_x, second_x;

    // Runner-up is empty until a second entry is seen; an empty runner-up yields margin 0.
    always_comb begin
        second_n     = second;
        second_vld_n = second_vld;
        if (load) begin
            second_n     = '0;
            second_vld_n = 1'b0;
        end else if (cur > best) begin
            second_n     = best;
            second_vld_n = 1'b1;
        end else if (!second_vld || cur > second) begin
            second_n     = cur;
            second_vld_n = 1'b1;
        end
        best_x   = best_n;
        second_x = second_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            second     <= '0;
            second_vld <= 1'b0;
            margin     <= '0;
        end else begin
            if (load || state == SCAN) begin
                second     <= second_n;
                second_vld <= second_vld_n;
            end
            if (finish) begin
                margin <= second_vld_n ? (best_x - second_x) : '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_argmax_sequencer.sv
// Directed vector table plus hand-written handshake, drop, back-to-back and reset sequences.
module tb_argmax_sequencer;

    localparam int N = 4;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                adder_done = 1'b1;
    logic signed [W-1:0] class_sums [N];
    logic                pred_ready = 1'b0;
    logic                pred_valid;
    logic [1:0]          pred_class;
    logic signed [W-1:0] pred_sum;
    logic                busy;
    logic [7:0]          drop_cnt;
`ifdef ARGMAX_MARGIN_EN
    logic signed [W:0]   margin;
`endif

    argmax_sequencer #(.CLASS_NUM(N), .WEIGHT_LENGTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adder_done (adder_done),
        .class_sums (class_sums),
        .pred_ready (pred_ready),
        .pred_valid (pred_valid),
        .pred_class (pred_class),
        .pred_sum   (pred_sum),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
`ifdef ARGMAX_MARGIN_EN
        ,
        .margin     (margin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0][W-1:0] sums;
        int                  exp_class;
        int                  exp_sum;
        int                  exp_margin;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int exp_drop = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sums(input logic [N-1:0][W-1:0] s);
        for (int i = 0; i < N; i++) class_sums[i] = $signed(s[i]);
    endtask

    task automatic bump_drop();
        exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
    endtask

    // Starts a scan from IDLE and leaves the DUT in DONE with pred_ready low.
    task automatic scan_to_done(input logic [N-1:0][W-1:0] s, input string tag);
        logic [N-1:0][W-1:0] junk;
        junk = {N{16'sd30000}};
        @(negedge clk);
        set_sums(s);
        adder_done = 1'b1;
        tick();
        chk({tag, "_busy_e1"}, busy, 1);
        @(negedge clk);
        set_sums(junk);
        for (int e = 2; e <= N; e++) begin
            chk({tag, "_valid_pre"}, pred_valid, 0);
            tick();
        end
        chk({tag, "_valid_e4"}, pred_valid, 1);
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        adder_done = 1'b0;
        pred_ready = 1'b1;
        tick();
        chk({tag, "_drop_valid"}, pred_valid, 0);
        chk({tag, "_idle"}, busy, 0);
        @(negedge clk);
        pred_ready = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        // sums packed as {s3, s2, s1, s0}
        vecs[0] = '{ {16'sd1, 16'sd7, -16'sd2, 16'sd3},                0, 7, 4 };
        vecs[1] = '{ {16'sd5, -16'sd1, 16'sd5, 16'sd5},                0, 5, 0 };
        vecs[2] = '{ {-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768}, 0, -32768, 0 };
        vecs[3] = '{ {-16'sd2, -16'sd3, -16'sd5, -16'sd1},             0, -1, 1 };
        vecs[4] = '{ {16'sd32767, 16'sd3, 16'sd2, 16'sd1},             3, 32767, 32764 };
        vecs[5] = '{ {16'sd0, 16'sd0, -16'sd32768, 16'sd32767},        0, 32767, 32767 };
        vecs[6] = '{ {-16'sd32768, -16'sd32768, 16'sd32767, -16'sd32768}, 1, 32767, 65535 };
        vecs[0].exp_class = 2;

        set_sums('0);
        #12;
        chk("rst_valid", pred_valid, 0);
        chk("rst_class", pred_class, 0);
        chk("rst_sum", pred_sum, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
`ifdef ARGMAX_MARGIN_EN
        chk("rst_margin", margin, 0);
`endif
        // adder_done held high across reset release must not start a scan
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rel_no_start", busy, 0);
        @(negedge clk);
        adder_done = 1'b0;
        tick();

        foreach (vecs[k]) begin
            scan_to_done(vecs[k].sums, "vec");
            chk("vec_class", pred_class, vecs[k].exp_class);
            chk("vec_sum", pred_sum, vecs[k].exp_sum);
`ifdef ARGMAX_MARGIN_EN
            chk("vec_margin", margin, vecs[k].exp_margin);
`endif
            accept("vec");
        end

        // Hold for 10 cycles with pred_ready low; a second rise in DONE is dropped.
        scan_to_done(vecs[0].sums, "hold");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 3) adder_done = 1'b0;
            if (c == 5) begin
                adder_done = 1'b1;
                set_sums({16'sd100, 16'sd100, 16'sd100, 16'sd100});
                bump_drop();
            end
            tick();
            chk("hold_valid", pred_valid, 1);
            chk("hold_class", pred_class, 2);
            chk("hold_sum", pred_sum, 7);
        end
        chk("hold_drop", drop_cnt, exp_drop);
        chk("hold_drop1", drop_cnt, 1);

        // Back-to-back: accept and start on the same edge.
        @(negedge clk);
        adder_done = 1'b0;
        tick();
        @(negedge clk);
        adder_done = 1'b1;
        pred_ready = 1'b1;
        set_sums({16'sd9, -16'sd4, 16'sd9, 16'sd0});
        tick();
        chk("b2b_valid_e1", pred_valid, 0);
        chk("b2b_busy_e1", busy, 1);
        @(negedge clk);
        pred_ready = 1'b0;
        tick();
        chk("b2b_valid_e2", pred_valid, 0);
        tick();
        chk("b2b_valid_e3", pred_valid, 0);
        tick();
        chk("b2b_valid_e4", pred_valid, 1);
        chk("b2b_class", pred_class, 1);
        chk("b2b_sum", pred_sum, 9);
`ifdef ARGMAX_MARGIN_EN
        chk("b2b_margin", margin, 0);
`endif
        chk("b2b_no_drop", drop_cnt, exp_drop);
        accept("b2b");

        // 300 dropped starts saturate the counter.
        scan_to_done(vecs[3].sums, "sat");
        for (int r = 0; r < 300; r++) begin
            @(negedge clk);
            adder_done = 1'b0;
            tick();
            @(negedge clk);
            adder_done = 1'b1;
            bump_drop();
            tick();
        end
        chk("sat_drop", drop_cnt, exp_drop);
        chk("sat_255", drop_cnt, 255);
        chk("sat_valid", pred_valid, 1);
        chk("sat_sum", pred_sum, -1);
        accept("sat");
        chk("sat_hold", drop_cnt, 255);

        // Reset in the middle of a scan discards the result.
        @(negedge clk);
        set_sums(vecs[4].sums);
        adder_done = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", pred_valid, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("post_rst_valid", pred_valid, 0);
        end
        chk("post_rst_idle", busy, 0);
        chk("post_rst_class", pred_class, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
